// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared memory-port types and arbiter constants
package mem_port_arbiter_pkg;
  localparam int ARB_MAX_OUTSTANDING_LIMIT = 4;
  localparam int ARB_CNT_W = $clog2(ARB_MAX_OUTSTANDING_LIMIT + 1);
  typedef enum logic [0:0] {OWN_I, OWN_D} ArbOwner;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  fcn;
    logic [2:0]  typ;
  } MemReq;
  typedef struct packed {
    MemReq req;
    logic  req_valid;
  } MemoryIn;
  typedef struct packed {
    logic [31:0] data;
  } MemRes;
  typedef struct packed {
    MemRes res;
    logic  req_ready;
    logic  res_valid;
  } MemoryOut;
endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// mem_port_arbiter_owner_fifo: in-order record of which requester owns each outstanding request
module mem_port_arbiter_owner_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  ArbOwner              push_owner,
  input  logic                 pop,
  output ArbOwner              head,
  output logic [ARB_CNT_W-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  ArbOwner slots [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign head = slots[rd_ptr];
  // payload storage needs no reset; count gates every read
  always_ff @(posedge clk)
    if (push) slots[wr_ptr] <= push_owner;
  // circular pointers and occupancy, push and pop may coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + ARB_CNT_W'(push) - ARB_CNT_W'(pop);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters with bounded fetch starvation
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  MemoryIn  imem_in,
  output MemoryOut imem_out,
  input  MemoryIn  dmem_in,
  output MemoryOut dmem_out,
  output MemoryIn  mem_in,
  input  MemoryOut mem_out,
  output logic     err_orphan
);
  logic [ARB_CNT_W-1:0] count;
  ArbOwner head;
  logic [3:0] starve_cnt;
  logic busy, pop, room, force_i, grant_d, ready, accept;
  // grant, request mux and response routing are purely combinational
  always_comb begin
    busy               = count != '0;
    pop                = mem_out.res_valid && busy && !reset;
    room               = (count < ARB_CNT_W'(MAX_OUTSTANDING)) || pop;
    force_i            = starve_cnt == 4'(STARVE_LIMIT);
    grant_d            = dmem_in.req_valid && !(imem_in.req_valid && force_i);
    ready              = mem_out.req_ready && room && !reset;
    mem_in.req         = grant_d ? dmem_in.req : imem_in.req;
    mem_in.req_valid   = (grant_d ? dmem_in.req_valid : imem_in.req_valid) && room && !reset;
    accept             = mem_in.req_valid && mem_out.req_ready;
    imem_out.res       = mem_out.res;
    imem_out.req_ready = ready && !grant_d;
    imem_out.res_valid = pop && head == OWN_I;
    dmem_out.res       = mem_out.res;
    dmem_out.req_ready = ready && grant_d;
    dmem_out.res_valid = pop && head == OWN_D;
  end
  // count consecutive data wins while fetch waits; any fetch win or idle fetch clears it
  always_ff @(posedge clk) begin
    if (reset || !imem_in.req_valid || (accept && !grant_d)) starve_cnt <= '0;
    else if (accept && starve_cnt != 4'hf) starve_cnt <= starve_cnt + 4'd1;
  end
  // a response with nothing outstanding is dropped and flagged until reset
  always_ff @(posedge clk) begin
    if (reset) err_orphan <= 1'b0;
    else if (mem_out.res_valid && !busy) err_orphan <= 1'b1;
  end
  mem_port_arbiter_owner_fifo #(.DEPTH(MAX_OUTSTANDING)) u_owner_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (accept),
    .push_owner(grant_d ? OWN_D : OWN_I),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a queue-based model
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;
  localparam int MAXO = 2;
  localparam int LIM  = 3;
  logic clk = 0;
  logic reset;
  MemoryIn  imem_in, dmem_in, mem_in;
  MemoryOut imem_out, dmem_out, mem_out;
  logic err_orphan;
  int checks = 0;
  int errors = 0;
  ArbOwner oq[$];
  int  m_starve;
  bit  m_orphan;
  bit  e_gd, e_mv, e_ir, e_dr, e_irv, e_drv;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .imem_in(imem_in), .imem_out(imem_out),
    .dmem_in(dmem_in), .dmem_out(dmem_out),
    .mem_in(mem_in), .mem_out(mem_out),
    .err_orphan(err_orphan)
  );

  function automatic MemReq mk_req(input logic [31:0] a);
    MemReq r;
    r.addr = a;
    r.data = ~a;
    r.fcn  = a[1:0];
    r.typ  = a[4:2];
    return r;
  endfunction

  function automatic void model_eval();
    bit pop, room, iv, dv;
    iv   = imem_in.req_valid;
    dv   = dmem_in.req_valid;
    pop  = mem_out.res_valid && !reset && oq.size() > 0;
    room = oq.size() < MAXO || pop;
    e_gd  = dv && !(iv && m_starve >= LIM);
    e_mv  = (e_gd ? dv : iv) && room && !reset;
    e_ir  = !e_gd && mem_out.req_ready && room && !reset;
    e_dr  = e_gd && mem_out.req_ready && room && !reset;
    e_irv = pop && oq[0] == OWN_I;
    e_drv = pop && oq[0] == OWN_D;
  endfunction

  function automatic void model_commit();
    bit acc;
    model_eval();
    if (reset) begin
      oq.delete();
      m_starve = 0;
      m_orphan = 0;
      return;
    end
    acc = e_mv && mem_out.req_ready;
    if (mem_out.res_valid) begin
      if (oq.size() > 0) void'(oq.pop_front());
      else m_orphan = 1;
    end
    if (acc) oq.push_back(e_gd ? OWN_D : OWN_I);
    if (!imem_in.req_valid) m_starve = 0;
    else if (acc) m_starve = e_gd ? (m_starve < 15 ? m_starve + 1 : 15) : 0;
  endfunction

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv, input logic [31:0] da,
                       input logic mr, input logic rv, input logic [31:0] rd);
    imem_in.req_valid  = iv;
    imem_in.req        = mk_req(ia);
    dmem_in.req_valid  = dv;
    dmem_in.req        = mk_req(da);
    mem_out.req_ready  = mr;
    mem_out.res_valid  = rv;
    mem_out.res.data   = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    drive(1, 32'h40, 1, 32'h80, 1, 1, 32'h55);
    #1;
    checks++;
    if ({mem_in.req_valid, imem_out.req_ready, dmem_out.req_ready, imem_out.res_valid, dmem_out.res_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 00000",
               {mem_in.req_valid, imem_out.req_ready, dmem_out.req_ready, imem_out.res_valid, dmem_out.res_valid});
    end
    tick();
    #1;
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL reset_err_orphan: got %b, expected 0", err_orphan);
    end
    tick();
    reset = 0;
  endtask

  task automatic test_fetch_only();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(1, 32'h1000 + 32'(4 * k), 0, 0, 1, k > 0, 32'h0000_0013);
      #1;
      checks++;
      if ({imem_out.req_ready, mem_in.req_valid} !== 2'b11 || mem_in.req.addr !== 32'h1000 + 32'(4 * k)) begin
        errors++;
        $display("FAIL fetch_accept[%0d]: got ready/valid %b addr %h, expected 11 addr %h", k,
                 {imem_out.req_ready, mem_in.req_valid}, mem_in.req.addr, 32'h1000 + 32'(4 * k));
      end
      checks++;
      if (imem_out.res_valid !== (k > 0) || dmem_out.res_valid !== 1'b0) begin
        errors++;
        $display("FAIL fetch_resp[%0d]: got i/d res_valid %b%b, expected %b0", k,
                 imem_out.res_valid, dmem_out.res_valid, k > 0);
      end
      if (k > 0) begin
        checks++;
        if (imem_out.res.data !== 32'h0000_0013) begin
          errors++;
          $display("FAIL fetch_data[%0d]: got %h, expected 00000013", k, imem_out.res.data);
        end
      end
      tick();
    end
  endtask

  task automatic test_starvation();
    bit exp_d, prev_d;
    do_reset();
    prev_d = 0;
    for (int k = 0; k < 12; k++) begin
      exp_d = (k % 4) != 3;
      drive(1, 32'h2000 + 32'(4 * k), 1, 32'h3000 + 32'(4 * k), 1, k > 0, 32'(k));
      #1;
      checks++;
      if (dmem_out.req_ready !== exp_d || imem_out.req_ready !== !exp_d ||
          mem_in.req.addr !== (exp_d ? 32'h3000 : 32'h2000) + 32'(4 * k)) begin
        errors++;
        $display("FAIL starve_grant[%0d]: got d/i ready %b%b addr %h, expected %b%b addr %h", k,
                 dmem_out.req_ready, imem_out.req_ready, mem_in.req.addr, exp_d, !exp_d,
                 (exp_d ? 32'h3000 : 32'h2000) + 32'(4 * k));
      end
      if (k > 0) begin
        checks++;
        if (dmem_out.res_valid !== prev_d || imem_out.res_valid !== !prev_d) begin
          errors++;
          $display("FAIL starve_route[%0d]: got d/i res_valid %b%b, expected %b%b", k,
                   dmem_out.res_valid, imem_out.res_valid, prev_d, !prev_d);
        end
      end
      prev_d = exp_d;
      tick();
    end
  endtask

  task automatic test_backpressure();
    bit exp_r [5] = '{1, 1, 0, 1, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 1, 32'h300, 1, k == 3, 32'h77);
      #1;
      checks++;
      if (dmem_out.req_ready !== exp_r[k] || mem_in.req_valid !== exp_r[k] || imem_out.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: got d_ready %b valid %b i_ready %b, expected %b %b 0", k,
                 dmem_out.req_ready, mem_in.req_valid, imem_out.req_ready, exp_r[k], exp_r[k]);
      end
      if (k == 3) begin
        checks++;
        if (dmem_out.res_valid !== 1'b1) begin
          errors++;
          $display("FAIL backpressure_resp: got %b, expected 1", dmem_out.res_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_interleave();
    logic [31:0] addr [3] = '{32'h100, 32'h200, 32'h104};
    logic [31:0] rdat [5] = '{0, 0, 32'hA, 32'hB, 32'hC};
    bit          exp_d [5] = '{0, 0, 1, 0, 1};
    bit          exp_i [5] = '{0, 0, 0, 1, 0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(k == 1, 32'h200, k == 0 || k == 2, k == 0 ? 32'h100 : 32'h104, 1, k >= 2, rdat[k]);
      #1;
      if (k < 3) begin
        checks++;
        if (mem_in.req_valid !== 1'b1 || mem_in.req.addr !== addr[k]) begin
          errors++;
          $display("FAIL interleave_req[%0d]: got valid %b addr %h, expected 1 addr %h", k,
                   mem_in.req_valid, mem_in.req.addr, addr[k]);
        end
      end
      checks++;
      if (dmem_out.res_valid !== exp_d[k] || imem_out.res_valid !== exp_i[k]) begin
        errors++;
        $display("FAIL interleave_route[%0d]: got d/i res_valid %b%b, expected %b%b", k,
                 dmem_out.res_valid, imem_out.res_valid, exp_d[k], exp_i[k]);
      end
      if (k >= 2) begin
        checks++;
        if ((exp_d[k] ? dmem_out.res.data : imem_out.res.data) !== rdat[k]) begin
          errors++;
          $display("FAIL interleave_data[%0d]: got %h, expected %h", k,
                   exp_d[k] ? dmem_out.res.data : imem_out.res.data, rdat[k]);
        end
      end
      tick();
    end
  endtask

  task automatic test_orphan();
    do_reset();
    drive(0, 0, 0, 0, 1, 1, 32'hDEAD);
    #1;
    checks++;
    if ({imem_out.res_valid, dmem_out.res_valid, err_orphan} !== 3'b000) begin
      errors++;
      $display("FAIL orphan_drop: got i/d res_valid,err %b, expected 000",
               {imem_out.res_valid, dmem_out.res_valid, err_orphan});
    end
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_set: got %b, expected 1", err_orphan);
    end
    tick();
    tick();
    tick();
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orphan_sticky: got %b, expected 1", err_orphan);
    end
    do_reset();
    #1;
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL orphan_clear: got %b, expected 0", err_orphan);
    end
  endtask

  task automatic test_reset_outstanding();
    do_reset();
    drive(0, 0, 1, 32'h400, 1, 0, 0);
    tick();
    tick();
    reset = 1;
    #1;
    checks++;
    if ({dmem_out.req_ready, mem_in.req_valid} !== 2'b00) begin
      errors++;
      $display("FAIL rst_out_gate: got ready/valid %b, expected 00", {dmem_out.req_ready, mem_in.req_valid});
    end
    tick();
    reset = 0;
    drive(0, 0, 0, 0, 1, 1, 32'h99);
    #1;
    checks++;
    if ({imem_out.res_valid, dmem_out.res_valid, imem_out.req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rst_out_resp: got i/d res_valid,i_ready %b, expected 001",
               {imem_out.res_valid, dmem_out.res_valid, imem_out.req_ready});
    end
    tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    #1;
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL rst_out_orphan: got %b, expected 1", err_orphan);
    end
    tick();
  endtask

  task automatic test_random();
    logic iv, dv;
    logic [31:0] ia, da;
    bit i_acc, d_acc;
    do_reset();
    iv = 0;
    dv = 0;
    ia = 0;
    da = 0;
    i_acc = 1;
    d_acc = 1;
    for (int k = 0; k < 400; k++) begin
      if (!iv || i_acc) begin iv = $urandom_range(0, 3) != 0; ia = $urandom; end
      if (!dv || d_acc) begin dv = $urandom_range(0, 3) != 0; da = $urandom; end
      reset = $urandom_range(0, 59) == 0;
      drive(iv, ia, dv, da, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 2) != 0 && oq.size() > 0) || $urandom_range(0, 149) == 0, $urandom);
      #1;
      model_eval();
      checks++;
      if ({mem_in.req_valid, imem_out.req_ready, dmem_out.req_ready, imem_out.res_valid, dmem_out.res_valid, err_orphan} !==
          {e_mv, e_ir, e_dr, e_irv, e_drv, m_orphan}) begin
        errors++;
        $display("FAIL random_ctrl[%0d]: got v/ir/dr/irv/drv/err %b, expected %b", k,
                 {mem_in.req_valid, imem_out.req_ready, dmem_out.req_ready, imem_out.res_valid, dmem_out.res_valid, err_orphan},
                 {e_mv, e_ir, e_dr, e_irv, e_drv, m_orphan});
      end
      checks++;
      if (mem_in.req !== (e_gd ? dmem_in.req : imem_in.req) || dmem_out.res.data !== mem_out.res.data ||
          imem_out.res.data !== mem_out.res.data) begin
        errors++;
        $display("FAIL random_data[%0d]: got req %h, expected %h", k, mem_in.req, e_gd ? dmem_in.req : imem_in.req);
      end
      i_acc = iv && e_ir;
      d_acc = dv && e_dr;
      tick();
    end
    reset = 0;
  endtask

  initial begin
    reset = 1;
    drive(0, 0, 0, 0, 0, 0, 0);
    m_starve = 0;
    m_orphan = 0;
    @(negedge clk);
    test_reset();
    test_fetch_only();
    test_starvation();
    test_backpressure();
    test_interleave();
    test_orphan();
    test_reset_outstanding();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single backing memory port between the instruction-fetch requester and the data-memory requester of the pipelined core. It grants at most one request per cycle. Data requests have fixed priority, and a starvation counter bounds how long fetch can be held off. A small owner FIFO routes in-order responses back to the requester that issued them.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters
- MAX_OUTSTANDING, default 2: maximum accepted-but-unanswered requests, range 1..4.
- STARVE_LIMIT, default 3: number of consecutive data grants while fetch is pending before fetch is forced through, range 1..15.

Ports
- clk  input  1  core clock
- reset  input  1  synchronous, active-high
- imem_in  input  MemoryIn (70)  fetch request: req (addr, data, fcn, typ) and req_valid
- imem_out  output  MemoryOut (34)  fetch response data, req_ready, res_valid
- dmem_in  input  MemoryIn (70)  data request
- dmem_out  output  MemoryOut (34)  data response
- mem_in  output  MemoryIn (70)  request to the backing memory
- mem_out  input  MemoryOut (34)  backing memory ready and response
- err_orphan  output  1  sticky flag: a response arrived with no outstanding request

## Operation
- Acceptance condition: mem_in.req_valid && mem_out.req_ready && room.
- room = (count < MAX_OUTSTANDING) || pop_this_cycle.
- Grant selection, combinational:
  - Data wins when both req_valid are high, unless force_i is set.
  - force_i = (starve_cnt == STARVE_LIMIT).
- Outputs for the granted requester:
  - mem_in.req is the granted requester's req.
  - mem_in.req_valid = granted req_valid && room.
  - The granted requester's req_ready = mem_out.req_ready && room.
  - The loser's req_ready = 0.
- starve_cnt, 4 bits, saturating:
  - Increments on a cycle where a data request is accepted while imem_in.req_valid is high.
  - Clears when a fetch request is accepted, or when imem_in.req_valid is low.
- Owner FIFO, 1 bit per entry (OWN_I/OWN_D):
  - Push on acceptance.
  - Pop on mem_out.res_valid when count > 0.
- Response routing:
  - mem_out.res.data is broadcast to both imem_out.res and dmem_out.res.
  - res_valid goes only to the owner at the FIFO head.
- Orphan response: mem_out.res_valid with count == 0 sets err_orphan and is dropped. Both res_valid outputs stay 0.
- Responses from the backing memory are in order, and arrive at least one cycle after acceptance.

## Timing
- Grant, req_ready and the request mux are combinational from the inputs and current state. There is zero added request latency.
- Response path is combinational, mem_out to imem_out/dmem_out. There is zero added response latency.
- Push and pop in the same cycle: count is unchanged and the head advances correctly. This is legal even when count == MAX_OUTSTANDING.
- Reset, applied synchronously at any time:
  - FIFO is emptied, count = 0, starve_cnt = 0, err_orphan = 0.
  - All output valids and readies are 0 during reset.
  - Responses arriving after reset for pre-reset requests are treated as orphans.
- Requesters hold req stable while req_valid is high and req_ready is low. The arbiter may move the grant between cycles while a request is not yet accepted.
- mem_out.req_ready low: no acceptance, no state change except starve_cnt clearing when imem_in.req_valid is low.

## Structure
- Add to the shared package:
  - enum ArbOwner [0:0] {OWN_I, OWN_D}.
  - Parameter ARB_MAX_OUTSTANDING_LIMIT = 4.
- Sub-module owner_fifo: parameterised depth, 1-bit payload, circular pointers wrapping at depth, count register, simultaneous push/pop.
- The top level holds the grant logic, the starvation counter and the response routing.

## Test plan
- Only fetch active, memory always ready, response 1 cycle later:
  - Fetch accepted every cycle; imem_out.res_valid follows each by 1 cycle, data 0x0000_0013.
  - dmem_out.res_valid is never high.
- Both requesters valid every cycle, STARVE_LIMIT = 3: grant order is D,D,D,I,D,D,D,I…; starve_cnt never exceeds 3.
- MAX_OUTSTANDING = 2, memory withholds responses: the third request sees req_ready = 0. A response in the same cycle allows the third to be accepted, and count stays 2.
- Interleaved accepts D@0x100, I@0x200, D@0x104, with in-order responses 0xA, 0xB, 0xC: dmem_out gets 0xA, imem_out gets 0xB, dmem_out gets 0xC.
- mem_out.res_valid with nothing outstanding: err_orphan = 1 and stays 1 until reset; no requester sees res_valid.
- Reset asserted with 2 outstanding: after reset count = 0; the next response raises err_orphan.
